swap_exec: RTL and testbench

Storage-side executor for the memory-swap protocol. Holds a small register bank plus a temp word. Consumes the `w`/`sel` step stream that the swap controller drives: sel=1 saves A to temp, sel=2 copies B to A, sel=3 copies temp to B. Also provides a host load/read port, sequence checking, and completion/error reporting back to the system.

---
 rtl/swap_exec.sv | 93 +++++++++
 tb/tb_swap_exec.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/swap_exec.sv
// swap_exec: storage-side executor for the three-step memory-swap protocol
// Ports: clk, reset_n (async, active-low); w/sel step stream with addr_a/addr_b
// operands; load_en/load_addr/load_data host write; rd_addr -> rd_data (1-cycle);
// busy, done (1-cycle pulse), seq_err (sticky) with clr_err.
// Build option: define SWAP_SEQ_CHECK_EN for the step tracker and sequence checking.
module swap_exec #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             w,
  input  logic [1:0]       sel,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             seq_err,
  input  logic             clr_err
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] temp_q, rd_q, wd;
  logic [AW-1:0] a_q, b_q, wa;
  logic busy_q, done_q, save, copy, rest, we, ld_ok, busy_d;
`ifdef SWAP_SEQ_CHECK_EN
  typedef enum logic [1:0] {IDLE, SAVED, COPIED} st_t;
  st_t st_q, st_d;
  logic err_q, bad;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st_q <= IDLE;
    else st_q <= st_d;
  // any step other than the expected one, or a stalled sequence, aborts to IDLE
  always_comb begin
    save = w && sel == 2'd1 && st_q == IDLE;
    copy = w && sel == 2'd2 && st_q == SAVED;
    rest = w && sel == 2'd3 && st_q == COPIED;
    bad = w ? !(save || copy || rest) : st_q != IDLE;
    st_d = save ? SAVED : copy ? COPIED : IDLE;
    busy_d = st_d != IDLE;
    ld_ok = load_en && !w && st_q == IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else err_q <= bad || (err_q && !clr_err);
  assign seq_err = err_q;
`else
  logic unused_clr;
  always_comb begin
    save = w && sel == 2'd1;
    copy = w && sel == 2'd2;
    rest = w && sel == 2'd3;
    busy_d = w && sel != 2'd3;
    ld_ok = load_en && !w;
  end
  assign seq_err = 1'b0;
  assign unused_clr = clr_err;
`endif
  // single bank write port: copy/restore need w=1, host load needs w=0
  always_comb begin
    we = copy || rest || ld_ok;
    wa = copy ? a_q : rest ? b_q : load_addr;
    wd = copy ? mem_q[b_q] : rest ? temp_q : load_data;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      temp_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (we) mem_q[wa] <= wd;
      if (save) begin
        temp_q <= mem_q[addr_a];
        a_q <= addr_a;
        b_q <= addr_b;
      end
      rd_q <= mem_q[rd_addr];
      busy_q <= busy_d;
      done_q <= rest;
    end
  assign rd_data = rd_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_swap_exec.sv
// tb_swap_exec: directed vector table plus hand sequences for swap_exec
module tb_swap_exec;
`ifdef SWAP_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, w = 1'b0, load_en = 1'b0, clr_err = 1'b0;
  logic [1:0] sel = '0, addr_a = '0, addr_b = '0, load_addr = '0, rd_addr = '0;
  logic [7:0] load_data = '0, rd_data;
  logic busy, done, seq_err;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic w; logic [1:0] sel, a, b; logic le; logic [1:0] la; logic [7:0] ld;
    logic [1:0] ra; logic [7:0] rd; logic busy, done;
  } vec_t;
  vec_t tbl[$];

  swap_exec #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .w(w), .sel(sel), .addr_a(addr_a), .addr_b(addr_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .seq_err(seq_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w_, input logic [1:0] s_, a_, b_, input logic le_,
                     input logic [1:0] la_, input logic [7:0] ld_, input logic [1:0] ra_,
                     input logic clr_);
    w = w_; sel = s_; addr_a = a_; addr_b = b_; load_en = le_;
    load_addr = la_; load_data = ld_; rd_addr = ra_; clr_err = clr_;
    @(posedge clk);
    #1;
  endtask

  task automatic v(input logic w_, input logic [1:0] s_, a_, b_, input logic le_,
                   input logic [1:0] la_, input logic [7:0] ld_, input logic [1:0] ra_,
                   input logic [7:0] rd_, input logic bz_, dn_);
    tbl.push_back('{w_, s_, a_, b_, le_, la_, ld_, ra_, rd_, bz_, dn_});
  endtask

  initial begin
    v(0,0,0,0,1,0,8'h11,0, 8'h00,0,0);
    v(0,0,0,0,1,2,8'h22,0, 8'h11,0,0);
    v(1,1,0,2,0,0,8'h00,2, 8'h22,1,0);
    v(1,2,0,0,0,0,8'h00,0, 8'h11,1,0);
    v(1,3,0,0,0,0,8'h00,0, 8'h22,0,1);
    v(0,0,0,0,0,0,8'h00,2, 8'h11,0,0);
    v(0,0,0,0,0,0,8'h00,0, 8'h22,0,0);
    v(0,0,0,0,1,1,8'h5A,1, 8'h00,0,0);
    v(1,1,1,1,0,0,8'h00,1, 8'h5A,1,0);
    v(1,2,0,0,0,0,8'h00,1, 8'h5A,1,0);
    v(1,3,0,0,0,0,8'h00,1, 8'h5A,0,1);
    v(0,0,0,0,0,0,8'h00,1, 8'h5A,0,0);
    v(1,1,0,2,0,0,8'h00,3, 8'h00,1,0);
    v(1,2,0,0,1,3,8'hFF,3, 8'h00,1,0);
    v(1,3,0,0,0,0,8'h00,3, 8'h00,0,1);
    v(0,0,0,0,1,3,8'hFF,0, 8'h11,0,0);
    v(0,0,0,0,0,0,8'h00,3, 8'hFF,0,0);
    v(0,0,0,0,0,0,8'h00,2, 8'h22,0,0);
    v(1,1,2,3,0,0,8'h00,0, 8'h11,1,0);
    v(1,2,0,0,0,0,8'h00,0, 8'h11,1,0);
    v(1,3,0,0,0,0,8'h00,0, 8'h11,0,1);
    v(1,1,0,1,0,0,8'h00,2, 8'hFF,1,0);
    v(1,2,0,0,0,0,8'h00,3, 8'h22,1,0);
    v(1,3,0,0,0,0,8'h00,0, 8'h5A,0,1);
    v(0,0,0,0,0,0,8'h00,1, 8'h11,0,0);
    v(0,0,0,0,0,0,8'h00,3, 8'h22,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", rd_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", seq_err, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].ra, 0);
      chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].rd);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_err", i), seq_err, 0);
    end

    // save then restore, skipping copy
    cyc(1,1,0,2,0,0,0,2,0);
    chk("ooo_save_busy", busy, 1);
    chk("ooo_save_rd", rd_data, 8'hFF);
    cyc(1,3,0,0,0,0,0,2,0);
    chk("ooo_rest_err", seq_err, CHK);
    chk("ooo_rest_busy", busy, 0);
    chk("ooo_rest_done", done, !CHK);
    cyc(0,0,0,0,0,0,0,2,0);
    chk("ooo_mem2", rd_data, CHK ? 8'hFF : 8'h5A);
    chk("ooo_done_after", done, 0);
    chk("ooo_err_sticky", seq_err, CHK);
    cyc(0,0,0,0,0,0,0,0,1);
    chk("clr_err", seq_err, 0);
    // sel=0 step alongside clr_err: a new error outranks the clear
    cyc(1,0,0,0,0,0,0,0,1);
    chk("setwins_err", seq_err, CHK);
    chk("setwins_busy", busy, !CHK);
    chk("setwins_rd", rd_data, 8'h5A);
    cyc(0,0,0,0,0,0,0,0,1);
    chk("clr_err2", seq_err, 0);
    // abandoned sequence
    cyc(1,1,1,3,0,0,0,0,0);
    chk("abandon_busy1", busy, 1);
    cyc(0,0,0,0,0,0,0,0,0);
    chk("abandon_err", seq_err, CHK);
    chk("abandon_busy0", busy, 0);
    cyc(0,0,0,0,0,0,0,0,1);
    chk("abandon_clr", seq_err, 0);

    // reset in the middle of a swap
    cyc(1,1,0,1,0,0,0,2,0);
    chk("rst_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_err", seq_err, 0);
    @(posedge clk);
    #1;
    w = 0; sel = 0; reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,0,0,0,0,2'(i),0);
      chk($sformatf("rst_mem%0d", i), rd_data, 0);
      chk($sformatf("rst_done%0d", i), done, 0);
    end
    cyc(0,0,0,0,1,0,8'hAA,0,0);
    cyc(0,0,0,0,1,1,8'hBB,0,0);
    cyc(1,1,0,1,0,0,0,0,0);
    chk("post_save_busy", busy, 1);
    cyc(1,2,0,0,0,0,0,0,0);
    cyc(1,3,0,0,0,0,0,0,0);
    chk("post_done", done, 1);
    cyc(0,0,0,0,0,0,0,0,0);
    chk("post_mem0", rd_data, 8'hBB);
    chk("post_done_low", done, 0);
    cyc(0,0,0,0,0,0,0,1,0);
    chk("post_mem1", rd_data, 8'hAA);
    chk("post_err", seq_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
